// File: rtl/usb3_ep0out_buf.sv
// rtl/usb3_ep0out_buf.sv - EP0 OUT receive packet buffer with 2-clock read pipeline
module usb3_ep0out_buf #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              buf_ready,
  input  logic              buf_wr_start,
  input  logic              buf_wr_we,
  input  logic [31:0]       buf_wr_dat,
  input  logic              buf_wr_done,
  input  logic [ADDR_W+2:0] buf_wr_len,
  input  logic              buf_wr_abort,
  output logic              buf_ovf,
  output logic              rd_avail,
  output logic [ADDR_W+2:0] rd_len,
  input  logic              rd_pop,
  output logic [31:0]       rd_dat,
  output logic              rd_valid,
  output logic              rd_last,
  input  logic              rd_flush
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LW    = ADDR_W + 3;
  localparam logic [LW-1:0] MAX_LEN = LW'(4 * DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_FULL} state_t;

  state_t state, state_nxt;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   wr_addr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   rptr_inc;
  logic [ADDR_W:0]   nwords;
  logic              ovf_q;
  logic [ADDR_W-1:0] rd_addr;
  logic              p1_valid;
  logic              p1_last;

  logic restart, wr_fire, ovf_set, drop, commit, pop_ok, flush_ok, leave_full;

  // wptr reaching DEPTH (top bit set) means the buffer is full; no wrap
  assign rptr_inc  = rptr + 1'b1;
  assign buf_ready = (state != S_FULL);
  assign rd_avail  = (state == S_FULL);

  // next-state and per-cycle action strobes
  always_comb begin
    state_nxt  = state;
    restart    = 1'b0;
    wr_fire    = 1'b0;
    ovf_set    = 1'b0;
    drop       = 1'b0;
    commit     = 1'b0;
    pop_ok     = 1'b0;
    flush_ok   = 1'b0;
    leave_full = 1'b0;
    wr_addr    = buf_wr_start ? '0 : wptr;
    case (state)
      S_IDLE: begin
        if (buf_wr_start) begin
          state_nxt = S_RECV;
          restart   = 1'b1;
        end
      end
      S_RECV: begin
        if (buf_wr_we && !buf_wr_abort) begin
          if (wr_addr[ADDR_W]) ovf_set = 1'b1;
          else                 wr_fire = 1'b1;
        end
        if (buf_wr_abort) begin
          state_nxt = S_IDLE;
        end else if (buf_wr_start) begin
          restart = 1'b1;
        end else if (buf_wr_done) begin
          if (ovf_q || ovf_set || (buf_wr_len > MAX_LEN)) begin
            drop      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            commit    = 1'b1;
            state_nxt = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (rd_flush) begin
          flush_ok   = 1'b1;
          leave_full = 1'b1;
          state_nxt  = S_IDLE;
        end else begin
          pop_ok = rd_pop && (rptr < nwords);
          if (rd_valid && rd_last) begin
            leave_full = 1'b1;
            state_nxt  = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // payload RAM write port (contents need no reset)
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr[ADDR_W-1:0]] <= buf_wr_dat;
  end

  // write pointer, sticky overflow flag and drop pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr    <= '0;
      ovf_q   <= 1'b0;
      buf_ovf <= 1'b0;
    end else begin
      if (wr_fire)      wptr <= wr_addr + 1'b1;
      else if (restart) wptr <= '0;
      if (restart)      ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
      buf_ovf <= drop;
    end
  end

  // committed packet length, word count and read issue pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_len <= '0;
      nwords <= '0;
      rptr   <= '0;
    end else if (commit) begin
      rd_len <= buf_wr_len;
      nwords <= (ADDR_W+1)'((buf_wr_len + LW'(3)) >> 2);
      rptr   <= '0;
    end else begin
      if (leave_full) rd_len <= '0;
      if (pop_ok)     rptr   <= rptr_inc;
    end
  end

  // read pipeline: address register, then output register; flush squashes both
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr  <= '0;
      p1_valid <= 1'b0;
      p1_last  <= 1'b0;
      rd_dat   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      p1_valid <= pop_ok;
      if (pop_ok) begin
        rd_addr <= rptr[ADDR_W-1:0];
        p1_last <= (rptr_inc == nwords);
      end
      rd_valid <= p1_valid && !flush_ok;
      rd_last  <= p1_valid && p1_last && !flush_ok;
      if (p1_valid && !flush_ok) rd_dat <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_usb3_ep0out_buf.sv
// tb/tb_usb3_ep0out_buf.sv - scoreboard bench for usb3_ep0out_buf
module tb_usb3_ep0out_buf;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LW     = ADDR_W + 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          buf_ready;
  logic          buf_wr_start = 1'b0;
  logic          buf_wr_we = 1'b0;
  logic [31:0]   buf_wr_dat = '0;
  logic          buf_wr_done = 1'b0;
  logic [LW-1:0] buf_wr_len = '0;
  logic          buf_wr_abort = 1'b0;
  logic          buf_ovf;
  logic          rd_avail;
  logic [LW-1:0] rd_len;
  logic          rd_pop = 1'b0;
  logic [31:0]   rd_dat;
  logic          rd_valid;
  logic          rd_last;
  logic          rd_flush = 1'b0;

  usb3_ep0out_buf #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .buf_ready(buf_ready),
    .buf_wr_start(buf_wr_start), .buf_wr_we(buf_wr_we), .buf_wr_dat(buf_wr_dat),
    .buf_wr_done(buf_wr_done), .buf_wr_len(buf_wr_len), .buf_wr_abort(buf_wr_abort),
    .buf_ovf(buf_ovf), .rd_avail(rd_avail), .rd_len(rd_len), .rd_pop(rd_pop),
    .rd_dat(rd_dat), .rd_valid(rd_valid), .rd_last(rd_last), .rd_flush(rd_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic        last;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [31:0] wbuf [0:31];
  logic [31:0] hold_dat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: every returned word must match the head of the expected queue at its due cycle
  always @(negedge clk) begin
    if (!reset_n) begin
      hold_dat = '0;
    end else if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_dat", rd_dat, mon_e.dat);
        chk("rd_last", {31'd0, rd_last}, {31'd0, mon_e.last});
        chk("rd_latency", cyc, mon_e.due);
      end
      hold_dat = rd_dat;
    end else begin
      chk("rd_dat_hold", rd_dat, hold_dat);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        chk("rd_valid_missing", 32'd0, 32'd1);
        mon_e = exp_q.pop_front();
      end
    end
  end

  // kind: 0 committed, 1 dropped with overflow, 2 aborted
  task automatic send_pkt(input int n, input int len, input bit abort, input bit merge_last,
                          input bit gaps);
    int kind;
    kind = abort ? 2 : ((n > DEPTH || len > 4 * DEPTH) ? 1 : 0);
    buf_wr_start = 1'b1;
    tick();
    buf_wr_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) tick();
      buf_wr_we  = 1'b1;
      buf_wr_dat = wbuf[i];
      if (!(merge_last && i == n - 1)) begin
        tick();
        buf_wr_we = 1'b0;
      end
    end
    buf_wr_done  = 1'b1;
    buf_wr_abort = abort;
    buf_wr_len   = LW'(len);
    tick();
    buf_wr_done  = 1'b0;
    buf_wr_abort = 1'b0;
    buf_wr_we    = 1'b0;
    if (kind == 0) begin
      chk("commit_rd_avail", {31'd0, rd_avail}, 32'd1);
      chk("commit_rd_len", {25'd0, rd_len}, len);
      chk("commit_buf_ready", {31'd0, buf_ready}, 32'd0);
      chk("commit_buf_ovf", {31'd0, buf_ovf}, 32'd0);
    end else begin
      chk("drop_buf_ovf", {31'd0, buf_ovf}, (kind == 1) ? 32'd1 : 32'd0);
      chk("drop_rd_avail", {31'd0, rd_avail}, 32'd0);
      chk("drop_buf_ready", {31'd0, buf_ready}, 32'd1);
      tick();
      chk("drop_buf_ovf_pulse", {31'd0, buf_ovf}, 32'd0);
      chk("drop_rd_avail_after", {31'd0, rd_avail}, 32'd0);
    end
  endtask

  // read back a committed packet; flush_at = pop index that carries rd_flush (-1: none)
  task automatic drain(input int len, input bit b2b, input int flush_at);
    int   nw;
    int   issued;
    int   budget;
    exp_t e;
    nw = (len + 3) / 4;
    issued = 0;
    if (nw == 0) begin
      for (int i = 0; i < 4; i++) begin
        rd_pop = 1'b1;
        tick();
      end
      rd_pop = 1'b0;
      chk("zlp_rd_avail_hold", {31'd0, rd_avail}, 32'd1);
      rd_flush = 1'b1;
      tick();
      rd_flush = 1'b0;
      chk("zlp_flush_buf_ready", {31'd0, buf_ready}, 32'd1);
      chk("zlp_flush_rd_avail", {31'd0, rd_avail}, 32'd0);
      return;
    end
    while (issued < nw) begin
      if (!b2b) while ($urandom_range(0, 2) == 0) tick();
      rd_pop = 1'b1;
      if (issued == flush_at) begin
        rd_flush = 1'b1;
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].due >= cyc + 1) e = exp_q.pop_back();
        tick();
        rd_pop   = 1'b0;
        rd_flush = 1'b0;
        chk("flush_buf_ready", {31'd0, buf_ready}, 32'd1);
        chk("flush_rd_avail", {31'd0, rd_avail}, 32'd0);
        repeat (4) tick();
        chk("flush_queue_empty", exp_q.size(), 32'd0);
        return;
      end
      e.dat  = wbuf[issued];
      e.last = (issued == nw - 1);
      e.due  = cyc + 2;
      exp_q.push_back(e);
      issued++;
      tick();
      rd_pop = 1'b0;
    end
    rd_pop = 1'($urandom_range(0, 1));
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      tick();
      rd_pop = 1'b0;
      budget--;
    end
    rd_pop = 1'b0;
    chk("drain_timeout", exp_q.size(), 32'd0);
    chk("release_buf_ready", {31'd0, buf_ready}, 32'd1);
    chk("release_rd_avail", {31'd0, rd_avail}, 32'd0);
    chk("release_rd_len", {25'd0, rd_len}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_buf_ready"}, {31'd0, buf_ready}, 32'd1);
    chk({tag, "_rd_avail"}, {31'd0, rd_avail}, 32'd0);
    chk({tag, "_rd_len"}, {25'd0, rd_len}, 32'd0);
    chk({tag, "_rd_dat"}, rd_dat, 32'd0);
    chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    chk({tag, "_rd_last"}, {31'd0, rd_last}, 32'd0);
    chk({tag, "_buf_ovf"}, {31'd0, buf_ovf}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, len, fa;
    bit ab, ml;
    repeat (3) tick();
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // 5 words, 18 bytes, back-to-back pops
    for (int i = 0; i < 5; i++) wbuf[i] = 32'h03020100 + 32'h04040404 * i;
    send_pkt(5, 18, 1'b0, 1'b0, 1'b0);
    drain(18, 1'b1, -1);

    // zero-length packet
    send_pkt(0, 0, 1'b0, 1'b0, 1'b0);
    drain(0, 1'b1, -1);

    // 17 writes overflow the 16-word RAM
    for (int i = 0; i < 17; i++) wbuf[i] = $urandom;
    send_pkt(17, 68, 1'b0, 1'b0, 1'b0);

    // oversize length with a full RAM
    send_pkt(16, 65, 1'b0, 1'b0, 1'b0);

    // done and abort together
    send_pkt(3, 12, 1'b1, 1'b0, 1'b0);

    // second packet while FULL is ignored
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA5A50000 + i;
    send_pkt(4, 14, 1'b0, 1'b0, 1'b0);
    buf_wr_start = 1'b1;
    tick();
    buf_wr_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      buf_wr_we  = 1'b1;
      buf_wr_dat = 32'hDEAD0000 + i;
      tick();
    end
    buf_wr_we   = 1'b0;
    buf_wr_done = 1'b1;
    buf_wr_len  = LW'(3);
    tick();
    buf_wr_done = 1'b0;
    chk("full_ignore_rd_len", {25'd0, rd_len}, 32'd14);
    chk("full_ignore_rd_avail", {31'd0, rd_avail}, 32'd1);
    chk("full_ignore_buf_ovf", {31'd0, buf_ovf}, 32'd0);
    drain(14, 1'b1, -1);

    // flush on the third of back-to-back pops
    for (int i = 0; i < 6; i++) wbuf[i] = $urandom;
    send_pkt(6, 24, 1'b0, 1'b0, 1'b0);
    drain(24, 1'b1, 2);

    // reset asserted mid-RECV, then a fresh 3-word packet
    buf_wr_start = 1'b1;
    tick();
    buf_wr_start = 1'b0;
    buf_wr_we    = 1'b1;
    buf_wr_dat   = 32'h11111111;
    tick();
    buf_wr_we    = 1'b0;
    reset_n      = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) wbuf[i] = 32'h5A5A0000 + i;
    send_pkt(3, 11, 1'b0, 1'b0, 1'b0);
    drain(11, 1'b0, -1);

    // randomized packets against the packet-level model
    for (int k = 0; k < 40; k++) begin
      n  = int'($urandom_range(0, 18));
      ab = ($urandom_range(0, 7) == 0);
      ml = (n > 0) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      if (n > DEPTH)                       len = int'($urandom_range(0, 127));
      else if ($urandom_range(0, 5) == 0)  len = int'($urandom_range(65, 127));
      else if (n == 0)                     len = 0;
      else                                 len = int'($urandom_range(4 * (n - 1) + 1, 4 * n));
      send_pkt(n, len, ab, ml, 1'b1);
      if (!ab && n <= DEPTH && len <= 4 * DEPTH) begin
        fa = -1;
        if (len > 0 && $urandom_range(0, 4) == 0) fa = int'($urandom_range(0, (len + 3) / 4 - 1));
        drain(len, $urandom_range(0, 1) == 1, fa);
      end
      repeat (int'($urandom_range(0, 2))) tick();
    end

    repeat (3) tick();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
